// File: rtl/useq_trisc.sv
// useq_trisc: microprogrammed control sequencer with a writable microstore.
//
// Each cycle in which run=1 and the sequencer is not halted, the word at
// mem[upc] is executed. Its control field is registered onto out_sig, and
// upc advances according to the sequencing op: continue, conditional jump,
// call/return on a small hardware stack, load/decrement loop counter,
// wait-on-condition, or halt.
//
// Microinstruction layout (IW = OW+NCS+4+AW bits, MSB first):
//   ctrl[OW] | csel[NCS] | inv | op[3] | addr[AW]
//
// Ports:
//   clk        rising-edge clock
//   reset_n    synchronous reset, active low (microstore not cleared)
//   run        1 = execute one microinstruction per cycle, 0 = hold all state
//   cond       condition inputs; csel=0 selects constant 1, csel=k selects cond[k-1]
//   prog_we    microstore write enable (honoured regardless of reset/run)
//   prog_addr  microstore write address
//   prog_data  microstore write data
//   out_sig    registered control word
//   upc        current microprogram counter
//   halted     HALT has been executed
//   stack_ovf  sticky: CALL taken with the stack full
//   stack_unf  sticky: RET taken with the stack empty

module useq_trisc #(
  parameter int NCS = 3,
  parameter int CW  = (1 << NCS) - 1,
  parameter int OW  = 28,
  parameter int AW  = 6,
  parameter int SD  = 4,
  localparam int IW = OW + NCS + 4 + AW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          run,
  input  logic [CW-1:0] cond,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [IW-1:0] prog_data,
  output logic [OW-1:0] out_sig,
  output logic [AW-1:0] upc,
  output logic          halted,
  output logic          stack_ovf,
  output logic          stack_unf
);

  localparam int SPW = $clog2(SD + 1);
  localparam int SIW = (SD > 1) ? $clog2(SD) : 1;

  typedef enum logic [2:0] {
    OP_CONT  = 3'd0,
    OP_JMP   = 3'd1,
    OP_CALL  = 3'd2,
    OP_RET   = 3'd3,
    OP_LDCNT = 3'd4,
    OP_LOOP  = 3'd5,
    OP_WAIT  = 3'd6,
    OP_HALT  = 3'd7
  } op_e;

  logic [IW-1:0]  mem [0:(1 << AW)-1];
  logic [AW-1:0]  stack_q [0:SD-1];

  logic [IW-1:0]  word;
  logic [OW-1:0]  ctrl;
  logic [NCS-1:0] csel;
  logic           inv;
  op_e            op;
  logic [AW-1:0]  addr;
  logic [CW:0]    condv;
  logic           c;

  logic [AW-1:0]  upc_q, upc_d, upc_inc;
  logic [AW-1:0]  cnt_q, cnt_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic [SIW-1:0] push_idx, pop_idx;
  logic           push;
  logic [OW-1:0]  out_q;
  logic           halted_q, halted_d;
  logic           ovf_q, ovf_d;
  logic           unf_q, unf_d;
  logic           step;

  // Asynchronous fetch; a same-cycle write lands at the edge, so the
  // executing instruction is always the old contents.
  assign word = mem[upc_q];
  assign ctrl = word[IW-1 -: OW];
  assign csel = word[AW+3+NCS -: NCS];
  assign inv  = word[AW+3];
  assign op   = op_e'(word[AW+2:AW]);
  assign addr = word[AW-1:0];

  // Slot 0 of the select vector is the constant-true condition.
  assign condv = {cond, 1'b1};
  assign c     = condv[csel] ^ inv;

  assign step     = run & ~halted_q;
  assign upc_inc  = upc_q + AW'(1);
  assign push_idx = sp_q[SIW-1:0];
  assign pop_idx  = push_idx - SIW'(1);

  always_comb begin
    upc_d    = upc_inc;
    cnt_d    = cnt_q;
    sp_d     = sp_q;
    push     = 1'b0;
    halted_d = halted_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    case (op)
      OP_CONT: ;
      OP_JMP: begin
        if (c) upc_d = addr;
      end
      OP_CALL: begin
        if (c) begin
          if (sp_q < SPW'(SD)) begin
            push  = 1'b1;
            sp_d  = sp_q + SPW'(1);
            upc_d = addr;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      OP_RET: begin
        if (c) begin
          if (sp_q != '0) begin
            sp_d  = sp_q - SPW'(1);
            upc_d = stack_q[pop_idx];
          end else begin
            unf_d = 1'b1;
          end
        end
      end
      OP_LDCNT: cnt_d = addr;
      OP_LOOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - AW'(1);
          upc_d = addr;
        end
      end
      OP_WAIT: begin
        if (!c) upc_d = upc_q;
      end
      OP_HALT: begin
        upc_d    = upc_q;
        halted_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (prog_we) mem[prog_addr] <= prog_data;
  end

  // Stack contents need no reset: emptying is done by clearing sp.
  always_ff @(posedge clk) begin
    if (reset_n && step && push) stack_q[push_idx] <= upc_inc;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      upc_q    <= '0;
      out_q    <= '0;
      cnt_q    <= '0;
      sp_q     <= '0;
      halted_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else if (step) begin
      upc_q    <= upc_d;
      out_q    <= ctrl;
      cnt_q    <= cnt_d;
      sp_q     <= sp_d;
      halted_q <= halted_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign out_sig   = out_q;
  assign upc       = upc_q;
  assign halted    = halted_q;
  assign stack_ovf = ovf_q;
  assign stack_unf = unf_q;

endmodule

// File: tb/tb_useq_trisc.sv
// Directed testbench for useq_trisc with default parameters
// (NCS=3, OW=28, AW=6, SD=4, IW=41).

module tb_useq_trisc;

  localparam int NCS = 3;
  localparam int CW  = 7;
  localparam int OW  = 28;
  localparam int AW  = 6;
  localparam int SD  = 4;
  localparam int IW  = OW + NCS + 4 + AW;

  localparam logic [2:0] CONT  = 3'd0;
  localparam logic [2:0] JMP   = 3'd1;
  localparam logic [2:0] CALL  = 3'd2;
  localparam logic [2:0] RET   = 3'd3;
  localparam logic [2:0] LDCNT = 3'd4;
  localparam logic [2:0] LOOP  = 3'd5;
  localparam logic [2:0] WAITC = 3'd6;
  localparam logic [2:0] HALT  = 3'd7;

  logic          clk;
  logic          reset_n;
  logic          run;
  logic [CW-1:0] cond;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [IW-1:0] prog_data;
  logic [OW-1:0] out_sig;
  logic [AW-1:0] upc;
  logic          halted;
  logic          stack_ovf;
  logic          stack_unf;

  int checks = 0;
  int errors = 0;

  useq_trisc #(.NCS(NCS), .OW(OW), .AW(AW), .SD(SD)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .run       (run),
    .cond      (cond),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .out_sig   (out_sig),
    .upc       (upc),
    .halted    (halted),
    .stack_ovf (stack_ovf),
    .stack_unf (stack_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [IW-1:0] mk(input logic [OW-1:0] ctrl, input logic [NCS-1:0] csel,
                                       input logic inv, input logic [2:0] op,
                                       input logic [AW-1:0] addr);
    return {ctrl, csel, inv, op, addr};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [IW-1:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    step();
    prog_we   = 1'b0;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < (1 << AW); i++) wr(AW'(i), mk('0, '0, 1'b0, HALT, '0));
  endtask

  task automatic do_reset();
    run     = 1'b0;
    cond    = '0;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    run = 1'b0; cond = '0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    checks++;
    if ({upc, out_sig} !== '0) begin
      errors++; $display("FAIL reset_regs: upc=%0d out_sig=%h required 0/0", upc, out_sig);
    end
    checks++;
    if ({halted, stack_ovf, stack_unf} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b required 000", {halted, stack_ovf, stack_unf});
    end
  endtask

  task automatic test_sequence();
    logic [OW-1:0] exp_out [0:3];
    logic [AW-1:0] exp_upc [0:3];
    logic          exp_h   [0:3];
    exp_out = '{28'd1, 28'd2, 28'd3, 28'd3};
    exp_upc = '{6'd1, 6'd2, 6'd2, 6'd2};
    exp_h   = '{1'b0, 1'b0, 1'b1, 1'b1};
    clear_prog();
    wr(6'd0, mk(28'd1, 3'd0, 1'b0, CONT, '0));
    wr(6'd1, mk(28'd2, 3'd0, 1'b0, CONT, '0));
    wr(6'd2, mk(28'd3, 3'd0, 1'b0, HALT, '0));
    do_reset();
    checks++;
    if (upc !== 6'd0) begin
      errors++; $display("FAIL seq_start: upc=%0d required 0", upc);
    end
    run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (out_sig !== exp_out[i] || upc !== exp_upc[i] || halted !== exp_h[i]) begin
        errors++;
        $display("FAIL seq_step%0d: out=%h upc=%0d halted=%b required out=%h upc=%0d halted=%b",
                 i, out_sig, upc, halted, exp_out[i], exp_upc[i], exp_h[i]);
      end
    end
  endtask

  task automatic test_jump();
    logic          t_inv [0:4];
    logic [2:0]    t_cs  [0:4];
    logic [CW-1:0] t_cnd [0:4];
    logic [AW-1:0] t_exp [0:4];
    t_inv = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    t_cs  = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd0};
    t_cnd = '{7'b0000000, 7'b0000010, 7'b0000000, 7'b0000010, 7'b0000000};
    t_exp = '{6'd1, 6'd5, 6'd5, 6'd1, 6'd5};
    clear_prog();
    for (int i = 0; i < 5; i++) begin
      wr(6'd0, mk(28'h10, t_cs[i], t_inv[i], JMP, 6'd5));
      do_reset();
      cond = t_cnd[i];
      run  = 1'b1;
      step();
      checks++;
      if (upc !== t_exp[i]) begin
        errors++;
        $display("FAIL jmp_case%0d: upc=%0d required %0d", i, upc, t_exp[i]);
      end
    end
  endtask

  task automatic test_call_ret();
    clear_prog();
    wr(6'd0, mk(28'h01, 3'd0, 1'b0, CALL, 6'd8));
    wr(6'd8, mk(28'h08, 3'd0, 1'b0, RET,  6'd0));
    wr(6'd1, mk(28'h11, 3'd0, 1'b0, RET,  6'd0));
    wr(6'd2, mk(28'h22, 3'd0, 1'b0, HALT, 6'd0));
    do_reset();
    run = 1'b1;
    step();
    checks++;
    if (upc !== 6'd8 || out_sig !== 28'h01) begin
      errors++; $display("FAIL call_target: upc=%0d out=%h required 8/01", upc, out_sig);
    end
    step();
    checks++;
    if (upc !== 6'd1 || stack_ovf !== 1'b0 || stack_unf !== 1'b0) begin
      errors++; $display("FAIL ret_return: upc=%0d ovf=%b unf=%b required 1/0/0", upc, stack_ovf, stack_unf);
    end
    // A second RET with an emptied stack proves sp went back to 0.
    step();
    checks++;
    if (upc !== 6'd2 || stack_unf !== 1'b1 || stack_ovf !== 1'b0) begin
      errors++; $display("FAIL ret_empty_after_return: upc=%0d unf=%b ovf=%b required 2/1/0", upc, stack_unf, stack_ovf);
    end
    step();
    checks++;
    if (halted !== 1'b1 || out_sig !== 28'h22 || upc !== 6'd2) begin
      errors++; $display("FAIL call_halt: halted=%b out=%h upc=%0d required 1/22/2", halted, out_sig, upc);
    end
  endtask

  task automatic test_stack_limits();
    clear_prog();
    wr(6'd0, mk(28'h30, 3'd0, 1'b0, JMP,  6'd3));
    wr(6'd3, mk(28'h33, 3'd0, 1'b0, CALL, 6'd3));
    wr(6'd4, mk(28'h44, 3'd0, 1'b0, RET,  6'd0));
    wr(6'd5, mk(28'h55, 3'd0, 1'b0, HALT, 6'd0));
    do_reset();
    run = 1'b1;
    step();
    for (int i = 0; i < SD; i++) step();
    checks++;
    if (upc !== 6'd3 || stack_ovf !== 1'b0) begin
      errors++; $display("FAIL push_full: upc=%0d ovf=%b required 3/0", upc, stack_ovf);
    end
    step();
    checks++;
    if (upc !== 6'd4 || stack_ovf !== 1'b1) begin
      errors++; $display("FAIL overflow: upc=%0d ovf=%b required 4/1", upc, stack_ovf);
    end
    for (int i = 0; i < SD; i++) step();
    checks++;
    if (upc !== 6'd4 || stack_unf !== 1'b0) begin
      errors++; $display("FAIL pop_all: upc=%0d unf=%b required 4/0", upc, stack_unf);
    end
    step();
    checks++;
    if (upc !== 6'd5 || stack_unf !== 1'b1 || stack_ovf !== 1'b1) begin
      errors++; $display("FAIL underflow: upc=%0d unf=%b ovf=%b required 5/1/1", upc, stack_unf, stack_ovf);
    end
  endtask

  task automatic test_loop();
    int n_a;
    int cycles;
    clear_prog();
    wr(6'd0, mk(28'h0, 3'd0, 1'b0, LDCNT, 6'd3));
    wr(6'd1, mk(28'hA, 3'd0, 1'b0, CONT,  6'd0));
    wr(6'd2, mk(28'hB, 3'd0, 1'b0, LOOP,  6'd1));
    wr(6'd3, mk(28'hF, 3'd0, 1'b0, HALT,  6'd0));
    do_reset();
    run = 1'b1;
    n_a = 0;
    cycles = 0;
    while (halted !== 1'b1 && cycles < 50) begin
      step();
      cycles++;
      if (out_sig === 28'hA) n_a++;
    end
    checks++;
    if (halted !== 1'b1) begin
      errors++; $display("FAIL loop_timeout: halted=%b after %0d cycles required 1", halted, cycles);
    end
    checks++;
    if (n_a !== 4) begin
      errors++; $display("FAIL loop_count: ctrl A issued %0d times required 4", n_a);
    end
    checks++;
    if (cycles !== 10 || upc !== 6'd3 || out_sig !== 28'hF) begin
      errors++; $display("FAIL loop_end: cycles=%0d upc=%0d out=%h required 10/3/F", cycles, upc, out_sig);
    end
  endtask

  task automatic test_wait_freeze();
    int bad;
    clear_prog();
    wr(6'd0, mk(28'h21, 3'd1, 1'b0, WAITC, 6'd0));
    wr(6'd1, mk(28'h22, 3'd0, 1'b0, HALT,  6'd0));
    do_reset();
    cond = '0;
    run  = 1'b1;
    bad  = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (upc !== 6'd0 || out_sig !== 28'h21) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL wait_hold: %0d of 10 cycles moved, upc=%0d out=%h required 0/21", bad, upc, out_sig);
    end
    run  = 1'b0;
    cond = 7'b0000001;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (upc !== 6'd0 || out_sig !== 28'h21) begin
      errors++; $display("FAIL run_freeze: upc=%0d out=%h required 0/21", upc, out_sig);
    end
    run = 1'b1;
    step();
    checks++;
    if (upc !== 6'd1 || out_sig !== 28'h21) begin
      errors++; $display("FAIL wait_release: upc=%0d out=%h required 1/21", upc, out_sig);
    end
    step();
    checks++;
    if (halted !== 1'b1 || out_sig !== 28'h22) begin
      errors++; $display("FAIL wait_halt: halted=%b out=%h required 1/22", halted, out_sig);
    end
  endtask

  task automatic test_wrap_and_write();
    clear_prog();
    wr(6'd0,  mk(28'h3E, 3'd0, 1'b0, JMP,  6'd63));
    wr(6'd63, mk(28'h3F, 3'd0, 1'b0, CONT, 6'd0));
    do_reset();
    run = 1'b1;
    // Overwrite the executing word during its own execute cycle.
    prog_we   = 1'b1;
    prog_addr = 6'd0;
    prog_data = mk(28'h77, 3'd0, 1'b0, CONT, 6'd0);
    step();
    prog_we = 1'b0;
    checks++;
    if (upc !== 6'd63 || out_sig !== 28'h3E) begin
      errors++; $display("FAIL same_cycle_write: upc=%0d out=%h required 63/3E", upc, out_sig);
    end
    step();
    checks++;
    if (upc !== 6'd0 || out_sig !== 28'h3F) begin
      errors++; $display("FAIL upc_wrap: upc=%0d out=%h required 0/3F", upc, out_sig);
    end
    step();
    checks++;
    if (upc !== 6'd1 || out_sig !== 28'h77) begin
      errors++; $display("FAIL new_word: upc=%0d out=%h required 1/77", upc, out_sig);
    end
  endtask

  task automatic test_reset_midrun();
    clear_prog();
    wr(6'd0, mk(28'h0, 3'd0, 1'b0, LDCNT, 6'd5));
    wr(6'd1, mk(28'h31, 3'd0, 1'b0, CALL, 6'd4));
    wr(6'd4, mk(28'h34, 3'd0, 1'b0, LOOP, 6'd4));
    wr(6'd5, mk(28'h35, 3'd0, 1'b0, RET,  6'd0));
    wr(6'd2, mk(28'h36, 3'd0, 1'b0, HALT, 6'd0));
    do_reset();
    run = 1'b1;
    step(); step(); step();
    checks++;
    if (upc !== 6'd4 || out_sig !== 28'h34) begin
      errors++; $display("FAIL midrun_pre: upc=%0d out=%h required 4/34", upc, out_sig);
    end
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    checks++;
    if (upc !== 6'd0 || out_sig !== 28'h0 || halted !== 1'b0) begin
      errors++; $display("FAIL midrun_reset: upc=%0d out=%h halted=%b required 0/0/0", upc, out_sig, halted);
    end
    // Restart with a program that exposes leftover counter/stack state.
    run = 1'b0;
    wr(6'd0, mk(28'h40, 3'd0, 1'b0, LOOP, 6'd9));
    wr(6'd1, mk(28'h41, 3'd0, 1'b0, RET,  6'd9));
    run = 1'b1;
    step();
    checks++;
    if (upc !== 6'd1) begin
      errors++; $display("FAIL cnt_cleared: upc=%0d required 1", upc);
    end
    step();
    checks++;
    if (upc !== 6'd2 || stack_unf !== 1'b1) begin
      errors++; $display("FAIL stack_cleared: upc=%0d unf=%b required 2/1", upc, stack_unf);
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_jump();
    test_call_ret();
    test_stack_limits();
    test_loop();
    test_wait_freeze();
    test_wrap_and_write();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
